// File: rtl/nibble_alu_sequencer_pkg.sv
// Shared types for the nibble ALU sequencer: op/state encodings and the
// control word the shared nibble loop expects for each kind of pass.
package nibble_alu_sequencer_pkg;

    localparam int WORD_W  = 32;
    localparam int NIB_W   = 3;
    localparam int SHAMT_W = 5;

    localparam logic [NIB_W-1:0] LAST_NIBBLE = 3'd7;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_LTU = 3'd2,
        OP_EQ  = 3'd3,
        OP_SHR = 3'd4
    } seq_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_NEXT  = 3'd3,
        ST_RESP  = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        CMD_ADD   = 2'd0,
        CMD_COMP  = 2'd1,
        CMD_XNOR  = 2'd2,
        CMD_RSHFT = 2'd3
    } alu_cmd_e;

    typedef struct packed {
        alu_cmd_e cmd;
        logic     b_inv;
        logic     carry_in;
        logic     carry_disable;
    } alu_ctrl_t;

    // COMP computes A-B-1, so its carry-out is set exactly when A > B.
    localparam alu_ctrl_t CTRL_ADD = '{cmd: CMD_ADD,   b_inv: 1'b0, carry_in: 1'b0, carry_disable: 1'b0};
    localparam alu_ctrl_t CTRL_SUB = '{cmd: CMD_ADD,   b_inv: 1'b1, carry_in: 1'b1, carry_disable: 1'b0};
    localparam alu_ctrl_t CTRL_LTU = '{cmd: CMD_COMP,  b_inv: 1'b0, carry_in: 1'b0, carry_disable: 1'b0};
    localparam alu_ctrl_t CTRL_EQ  = '{cmd: CMD_XNOR,  b_inv: 1'b0, carry_in: 1'b0, carry_disable: 1'b0};
    localparam alu_ctrl_t CTRL_SHR = '{cmd: CMD_RSHFT, b_inv: 1'b0, carry_in: 1'b0, carry_disable: 1'b0};

    function automatic alu_ctrl_t ctrl_for_op(input seq_op_e op);
        case (op)
            OP_ADD:  return CTRL_ADD;
            OP_SUB:  return CTRL_SUB;
            OP_LTU:  return CTRL_LTU;
            OP_EQ:   return CTRL_EQ;
            OP_SHR:  return CTRL_SHR;
            default: return CTRL_ADD;
        endcase
    endfunction

    // EQ and SHR always span the whole word regardless of the requested width.
    function automatic logic [NIB_W-1:0] nibbles_for_op(input seq_op_e op,
                                                       input logic [NIB_W-1:0] requested);
        if (op == OP_EQ || op == OP_SHR)
            return LAST_NIBBLE;
        return requested;
    endfunction

endpackage

// File: rtl/nibble_alu_sequencer_if.sv
// Request/response port of the nibble ALU sequencer: one op per req
// handshake, one result word plus flag per resp handshake.
interface nibble_alu_sequencer_if;
    import nibble_alu_sequencer_pkg::*;

    logic                req_valid;
    logic                req_ready;
    seq_op_e             req_op;
    logic [WORD_W-1:0]   req_a;
    logic [WORD_W-1:0]   req_b;
    logic [NIB_W-1:0]    req_nibbles;
    logic                req_b_neg;
    logic [SHAMT_W-1:0]  req_shamt;

    logic                resp_valid;
    logic                resp_ready;
    logic [WORD_W-1:0]   resp_result;
    logic                resp_flag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_nibbles, req_b_neg, req_shamt,
        output resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_nibbles, req_b_neg, req_shamt,
        input  resp_ready,
        output req_ready, resp_valid, resp_result, resp_flag
    );

endinterface

// File: rtl/nibble_alu_sequencer.sv
// Command front-end for the shared nibble-serial ALU loop: accepts one op,
// sequences one or more loop passes and returns the result word and flag.
module nibble_alu_sequencer
    import nibble_alu_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    nibble_alu_sequencer_if.slave bus,

    output logic                  loop_perm_to_count,
    output logic [NIB_W-1:0]      loop_nibbles_number,
    output alu_ctrl_t             loop_ctrl,
    output logic                  loop_check_0xf,
    output logic                  loop_b_neg,
    output logic [WORD_W-1:0]     loop_word1,
    output logic [WORD_W-1:0]     loop_word2,
    output logic                  loop_preinit_only,
    output logic [WORD_W-1:0]     loop_preinit,
    input  logic                  loop_busy,
    input  logic [WORD_W-1:0]     loop_result,
    input  logic                  loop_carry
);

    seq_state_e          state_q, state_d;
    seq_op_e             op_q;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic [WORD_W-1:0]   res_q;
    logic [NIB_W-1:0]    nib_q;
    logic [1:0]          pass_cnt_q;
    logic                b_neg_q;
    logic                flag_q;
    logic                armed_q;
    logic                pre_pend_q;

    logic                accept;
    logic                run_done;
    logic [WORD_W-1:0]   shr_nibble_word;

    assign accept   = (state_q == ST_IDLE) && bus.req_valid;
    // The loop's busy lags perm_to_count by a cycle, so the first RUN cycle is blind.
    assign run_done = armed_q && !loop_busy;
    assign shr_nibble_word = bus.req_b >> {bus.req_shamt[4:2], 2'b00};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)                 state_d = ST_SETUP;
            ST_SETUP: state_d = (pass_cnt_q == 2'd0) ? ST_NEXT : ST_RUN;
            ST_RUN:   if (run_done)               state_d = ST_NEXT;
            ST_NEXT:  state_d = (pass_cnt_q > 2'd1) ? ST_SETUP : ST_RESP;
            ST_RESP:  if (bus.resp_ready)         state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        loop_perm_to_count = 1'b0;
        loop_preinit_only  = 1'b0;
        case (state_q)
            ST_IDLE:  bus.req_ready      = !rst;
            ST_SETUP: loop_preinit_only  = pre_pend_q;
            ST_RUN:   loop_perm_to_count = 1'b1;
            ST_RESP:  bus.resp_valid     = 1'b1;
            default:  ;
        endcase
    end

    assign bus.resp_result     = res_q;
    assign bus.resp_flag       = flag_q;
    assign loop_nibbles_number = nib_q;
    assign loop_ctrl           = ctrl_for_op(op_q);
    assign loop_check_0xf      = (op_q == OP_EQ);
    assign loop_b_neg          = b_neg_q;
    assign loop_word1          = a_q;
    assign loop_word2          = b_q;
    assign loop_preinit        = (op_q == OP_SHR) ? b_q : a_q;

    // Operand and result registers. For SHR, b_q carries the running shifted
    // word: whole nibbles are applied at accept, single bits by RSHFT passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            nib_q      <= '0;
            pass_cnt_q <= '0;
            b_neg_q    <= 1'b0;
            flag_q     <= 1'b0;
            armed_q    <= 1'b0;
            pre_pend_q <= 1'b0;
        end else begin
            armed_q <= (state_q == ST_RUN);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.req_op;
                        a_q     <= bus.req_a;
                        nib_q   <= nibbles_for_op(bus.req_op, bus.req_nibbles);
                        b_neg_q <= (bus.req_op == OP_ADD || bus.req_op == OP_SUB) && bus.req_b_neg;
                        flag_q  <= 1'b0;
                        if (bus.req_op == OP_SHR) begin
                            b_q        <= shr_nibble_word;
                            res_q      <= shr_nibble_word;
                            pass_cnt_q <= bus.req_shamt[1:0];
                            pre_pend_q <= |bus.req_shamt[4:2];
                        end else begin
                            b_q        <= bus.req_b;
                            pass_cnt_q <= 2'd1;
                            pre_pend_q <= 1'b0;
                        end
                    end
                end
                ST_SETUP: pre_pend_q <= 1'b0;
                ST_RUN: begin
                    if (run_done) begin
                        res_q <= loop_result;
                        if (op_q != OP_SHR)
                            flag_q <= loop_carry;
                    end
                end
                ST_NEXT: begin
                    if (pass_cnt_q > 2'd1) begin
                        b_q        <= res_q;
                        pass_cnt_q <= pass_cnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Self-checking bench for nibble_alu_sequencer: behavioural nibble-loop model,
// directed vectors, randomized ops against an arithmetic reference.
module tb_nibble_alu_sequencer;
    import nibble_alu_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_alu_sequencer_if bif ();

    logic              loop_perm_to_count;
    logic [2:0]        loop_nibbles_number;
    alu_ctrl_t         loop_ctrl;
    logic              loop_check_0xf;
    logic              loop_b_neg;
    logic [31:0]       loop_word1, loop_word2, loop_preinit;
    logic              loop_preinit_only;
    logic              loop_busy    = 1'b0;
    logic [31:0]       loop_result  = 32'hdead_beef;
    logic              loop_carry   = 1'b1;
    logic              loop_running = 1'b0;
    int                loop_wait    = 0;
    int                run_cycles   = 0;
    int                preinit_seen = 0;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_alu_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bif),
        .loop_perm_to_count  (loop_perm_to_count),
        .loop_nibbles_number (loop_nibbles_number),
        .loop_ctrl           (loop_ctrl),
        .loop_check_0xf      (loop_check_0xf),
        .loop_b_neg          (loop_b_neg),
        .loop_word1          (loop_word1),
        .loop_word2          (loop_word2),
        .loop_preinit_only   (loop_preinit_only),
        .loop_preinit        (loop_preinit),
        .loop_busy           (loop_busy),
        .loop_result         (loop_result),
        .loop_carry          (loop_carry)
    );

    // One pass of the nibble loop: operates on nibbles 0..n (whole word when b
    // is a short negative), upper result nibbles come from preinit.
    function automatic logic [32:0] loop_compute(input alu_ctrl_t c, input logic [2:0] n,
                                                 input logic bneg, input logic [31:0] w1,
                                                 input logic [31:0] w2, input logic [31:0] pre);
        logic [63:0] m64, sum;
        logic [31:0] m, w2e, op2, x;
        int          w;
        w   = 4 * (int'(n) + 1);
        m64 = (64'd1 << w) - 64'd1;
        w2e = w2;
        if (bneg) begin
            w2e = w2 | ~m64[31:0];
            w   = 32;
            m64 = 64'hffff_ffff;
        end
        m = m64[31:0];
        case (c.cmd)
            CMD_XNOR: begin
                x = ~(w1 ^ w2e) & m;
                return {x == m, x};
            end
            CMD_RSHFT: return {1'b0, w2e >> 1};
            default: begin
                op2 = (c.b_inv || c.cmd == CMD_COMP) ? ~w2e : w2e;
                sum = {32'd0, w1 & m} + {32'd0, op2 & m} + {63'd0, c.carry_in};
                return {sum[w], (pre & ~m) | (sum[31:0] & m)};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (!loop_perm_to_count) begin
            loop_busy    <= 1'b0;
            loop_running <= 1'b0;
            loop_result  <= 32'hdead_beef;
            loop_carry   <= 1'b1;
        end else if (!loop_running) begin
            loop_running <= 1'b1;
            loop_busy    <= 1'b1;
            loop_wait    <= int'($urandom_range(0, 6));
            {loop_carry, loop_result} <= loop_compute(loop_ctrl, loop_nibbles_number, loop_b_neg,
                                                      loop_word1, loop_word2, loop_preinit);
        end else if (loop_wait != 0) begin
            loop_wait <= loop_wait - 1;
        end else begin
            loop_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (loop_perm_to_count) run_cycles   <= run_cycles + 1;
        if (loop_preinit_only)  preinit_seen <= preinit_seen + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input string tag, input seq_op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] n, input logic bneg,
                            input logic [4:0] shamt);
        int t;
        @(negedge clk);
        bif.req_valid   = 1'b1;
        bif.req_op      = op;
        bif.req_a       = a;
        bif.req_b       = b;
        bif.req_nibbles = n;
        bif.req_b_neg   = bneg;
        bif.req_shamt   = shamt;
        t = 0;
        while (bif.req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_req_timeout"}, 32'(t < 50), 32'd1);
        @(negedge clk);
        bif.req_valid = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [31:0] exp_res, input bit chk_res,
                            input logic exp_flag, input bit chk_flag);
        int t;
        int hold;
        t = 0;
        while (bif.resp_valid !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_resp_timeout"}, 32'(t < 300), 32'd1);
        check({tag, "_busy_not_ready"}, 32'(bif.req_ready), 32'd0);
        hold = int'($urandom_range(0, 3));
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_valid_held"}, 32'(bif.resp_valid), 32'd1);
        end
        if (chk_res)  check({tag, "_result"}, bif.resp_result, exp_res);
        if (chk_flag) check({tag, "_flag"}, 32'(bif.resp_flag), 32'(exp_flag));
        bif.resp_ready = 1'b1;
        @(negedge clk);
        bif.resp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bif.resp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bif.req_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input seq_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] n, input logic bneg,
                         input logic [4:0] shamt, input logic [31:0] exp_res, input bit chk_res,
                         input logic exp_flag, input bit chk_flag);
        send_req(tag, op, a, b, n, bneg, shamt);
        get_resp(tag, exp_res, chk_res, exp_flag, chk_flag);
    endtask

    initial begin
        int          t, seen, runs_before, pre_before;
        seq_op_e     op;
        logic [31:0] a, b, exp_res;
        logic [32:0] s;
        logic [4:0]  shamt;
        logic        exp_flag;
        bit          chk_res;

        bif.req_valid = 1'b0;  bif.req_op = OP_ADD; bif.req_a = '0; bif.req_b = '0;
        bif.req_nibbles = '0;  bif.req_b_neg = 1'b0; bif.req_shamt = '0; bif.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_ready",   32'(bif.req_ready),       32'd0);
        check("rst_resp_valid",  32'(bif.resp_valid),      32'd0);
        check("rst_perm",        32'(loop_perm_to_count),  32'd0);
        check("rst_preinit",     32'(loop_preinit_only),   32'd0);
        check("rst_result",      bif.resp_result,          32'd0);
        check("rst_flag",        32'(bif.resp_flag),       32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bif.req_ready), 32'd1);

        do_op("add_carry_chain", OP_ADD, 32'h0000_0aff, 32'h1, 3'd7, 1'b0, 5'd0, 32'h0000_0b00, 1, 1'b0, 1);
        do_op("sub",             OP_SUB, 32'h0000_1000, 32'h0000_0500, 3'd7, 1'b0, 5'd0, 32'h0000_0b00, 1, 1'b1, 1);
        do_op("add_short_neg",   OP_ADD, 32'h0000_ffff, 32'h0000_00ff, 3'd1, 1'b1, 5'd0, 32'h0000_fffe, 1, 1'b1, 1);
        do_op("ltu_equal",       OP_LTU, 32'h1234_1234, 32'h1234_1234, 3'd7, 1'b0, 5'd0, 32'd0, 0, 1'b0, 1);
        do_op("ltu_greater",     OP_LTU, 32'h1234_1234, 32'h1234_1233, 3'd7, 1'b0, 5'd0, 32'd0, 0, 1'b1, 1);
        do_op("eq_same",         OP_EQ,  32'h1234_1234, 32'h1234_1234, 3'd0, 1'b0, 5'd0, 32'd0, 0, 1'b1, 1);
        do_op("eq_top_differs",  OP_EQ,  32'h2234_1234, 32'h1234_1234, 3'd0, 1'b0, 5'd0, 32'd0, 0, 1'b0, 1);
        do_op("shr_1",           OP_SHR, 32'h0, 32'h0600_0000, 3'd0, 1'b0, 5'd1, 32'h0300_0000, 1, 1'b0, 0);

        pre_before = preinit_seen;
        do_op("shr_6",           OP_SHR, 32'h0, 32'h0600_0000, 3'd0, 1'b0, 5'd6, 32'h0018_0000, 1, 1'b0, 0);
        check("shr_6_preinit_pulses", 32'(preinit_seen - pre_before), 32'd1);

        runs_before = run_cycles;
        do_op("shr_0",           OP_SHR, 32'h0, 32'h0600_0000, 3'd0, 1'b0, 5'd0, 32'h0600_0000, 1, 1'b0, 0);
        check("shr_0_no_run", 32'(run_cycles - runs_before), 32'd0);

        // Abort a multi-pass shift in the middle of a RUN pass.
        send_req("abort", OP_SHR, 32'h0, 32'h0600_0000, 3'd0, 1'b0, 5'd3);
        t = 0;
        while (loop_perm_to_count !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("abort_run_seen", 32'(t < 20), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_perm_low",   32'(loop_perm_to_count), 32'd0);
        check("abort_no_valid",   32'(bif.resp_valid),     32'd0);
        check("abort_ready_low",  32'(bif.req_ready),      32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bif.resp_valid === 1'b1 || loop_perm_to_count === 1'b1) seen++;
        end
        check("abort_dropped", 32'(seen), 32'd0);
        do_op("add_after_abort", OP_ADD, 32'd2, 32'd3, 3'd7, 1'b0, 5'd0, 32'd5, 1, 1'b0, 1);

        // Random full-width ops against plain arithmetic.
        for (int i = 0; i < 30; i++) begin
            op    = seq_op_e'(3'($urandom_range(0, 4)));
            a     = $urandom;
            b     = ($urandom_range(0, 3) == 0) ? a : $urandom;
            shamt = 5'($urandom_range(0, 31));
            chk_res  = 1;
            exp_flag = 1'b0;
            case (op)
                OP_ADD: begin
                    s = {1'b0, a} + {1'b0, b};
                    exp_res = s[31:0];  exp_flag = s[32];
                end
                OP_SUB: begin exp_res = a - b;     exp_flag = (a >= b); end
                OP_LTU: begin exp_res = '0;        exp_flag = (a > b);  chk_res = 0; end
                OP_EQ:  begin exp_res = '0;        exp_flag = (a == b); chk_res = 0; end
                default: exp_res = b >> shamt;
            endcase
            do_op($sformatf("rand%0d_op%0d", i, int'(op)), op, a, b, 3'd7, 1'b0, shamt,
                  exp_res, chk_res, exp_flag, op != OP_SHR);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
